// File: rtl/navigate.sv
// Motion-execution FSM: turns heading-change / forward-move requests into a ramped
// forward-speed command and reports completion with a single-cycle mv_cmplt.
module navigate #(
  parameter bit          FAST_SIM  = 1'b0,
  parameter logic [10:0] MAX_FRWRD = 11'h2A0,
  parameter logic [10:0] MIN_FRWRD = 11'h0D0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_hdng_i,
  input  logic        strt_mv_i,
  input  logic        stp_lft_i,
  input  logic        stp_rght_i,
  input  logic        hdng_rdy_i,
  input  logic        at_hdng_i,
  input  logic        lft_opn_i,
  input  logic        rght_opn_i,
  input  logic        frwrd_opn_i,
  output logic        mv_cmplt_o,
  output logic        moving_o,
  output logic        en_fusion_o,
  output logic [10:0] frwrd_spd_o
);

  localparam logic [10:0] FRWRD_INC = FAST_SIM ? 11'h018 : 11'h002;
  localparam logic [11:0] INC12     = {1'b0, FRWRD_INC};
  localparam logic [11:0] DEC_NORM_AMT = INC12 << 1;
  localparam logic [11:0] DEC_FAST_AMT = INC12 << 2;

  typedef enum logic [2:0] {IDLE, HDNG, ACCEL, DEC_NORM, DEC_FAST} state_t;

  state_t      state_q, state_d;
  logic [10:0] spd_q, spd_d;
  logic        lft_ff_q, rght_ff_q;

  logic        lft_rise, rght_rise;
  logic [11:0] inc_sum, dec_amt, dec_res;
  logic        dec_stop;

  assign lft_rise  = lft_opn_i & ~lft_ff_q;
  assign rght_rise = rght_opn_i & ~rght_ff_q;

  // Arithmetic is done at 12 bits so an underflow shows up in bit 11.
  assign inc_sum  = {1'b0, spd_q} + INC12;
  assign dec_amt  = (state_q == DEC_FAST) ? DEC_FAST_AMT : DEC_NORM_AMT;
  assign dec_res  = {1'b0, spd_q} - dec_amt;
  assign dec_stop = dec_res[11] | (dec_res < {1'b0, MIN_FRWRD});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      spd_q     <= '0;
      lft_ff_q  <= 1'b0;
      rght_ff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      spd_q     <= spd_d;
      lft_ff_q  <= lft_opn_i;
      rght_ff_q <= rght_opn_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    spd_d      = spd_q;
    mv_cmplt_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (strt_hdng_i) begin
          state_d = HDNG;
        end else if (strt_mv_i) begin
          spd_d   = MIN_FRWRD;
          state_d = frwrd_opn_i ? ACCEL : DEC_FAST;
        end
      end
      HDNG: begin
        spd_d = '0;
        if (at_hdng_i) begin
          mv_cmplt_o = 1'b1;
          state_d    = IDLE;
        end
      end
      ACCEL: begin
        if (!frwrd_opn_i) begin
          state_d = DEC_FAST;
        end else if ((stp_lft_i & lft_rise) | (stp_rght_i & rght_rise)) begin
          state_d = DEC_NORM;
        end else if (hdng_rdy_i) begin
          spd_d = (inc_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : inc_sum[10:0];
        end
      end
      DEC_NORM, DEC_FAST: begin
        // A finished stop takes priority over escalating to the fast ramp.
        if (hdng_rdy_i && dec_stop) begin
          spd_d      = '0;
          mv_cmplt_o = 1'b1;
          state_d    = IDLE;
        end else begin
          if (hdng_rdy_i) spd_d = dec_res[10:0];
          if (state_q == DEC_NORM && !frwrd_opn_i) state_d = DEC_FAST;
        end
      end
      default: begin
        state_d = IDLE;
        spd_d   = '0;
      end
    endcase
  end

  assign frwrd_spd_o = spd_q;
  assign moving_o    = (state_q != IDLE);
  assign en_fusion_o = (spd_q > (MAX_FRWRD >> 1));

endmodule

// File: doc/navigate.md
Name: navigate

Overview:
- Motion-execution FSM directly downstream of the maze-solving controller.
- Takes the controller's heading-change and forward-move requests, plus its left/right stop-on-opening selection.
- Drives the forward-speed command to the PID/motor stage, with ramp-up, normal ramp-down and emergency ramp-down.
- Returns a single-cycle mv_cmplt that the controller uses to sequence its next decision.

Parameters:
- FAST_SIM, 0, when 1, FRWRD_INC = 11'h018 (simulation); when 0, FRWRD_INC = 11'h002.
- MAX_FRWRD, 11'h2A0, saturation ceiling for frwrd_spd.
- MIN_FRWRD, 11'h0D0, speed loaded at move start; also the stop threshold on deceleration.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- strt_hdng  in  1  request a heading change (pulse).
- strt_mv  in  1  request a forward move (pulse).
- stp_lft  in  1  stop the move on a rising edge of lft_opn.
- stp_rght  in  1  stop the move on a rising edge of rght_opn.
- hdng_rdy  in  1  speed-update strobe; frwrd_spd changes only in cycles where it is 1.
- at_hdng  in  1  PID reports the desired heading has been reached.
- lft_opn  in  1  left wall open.
- rght_opn  in  1  right wall open.
- frwrd_opn  in  1  path ahead clear; 0 means obstacle.
- mv_cmplt  out  1  one-cycle pulse when a heading change or move finishes.
- moving  out  1  high in every non-IDLE state.
- en_fusion  out  1  high while frwrd_spd > MAX_FRWRD>>1 (11'h150).
- frwrd_spd  out  11  forward speed command, registered.

Behaviour:
- Reset values: state = IDLE, frwrd_spd = 0, lft_opn/rght_opn edge registers = 0, mv_cmplt = 0, moving = 0, en_fusion = 0.
- Edge detection: lft_opn and rght_opn are registered every cycle, in all states.
  - lft_rise = lft_opn & ~lft_opn_ff; rght_rise likewise.
  - An opening already present when a move starts never counts as an edge.
- States: IDLE, HDNG, ACCEL, DEC_NORM, DEC_FAST.
- IDLE:
  - strt_hdng -> HDNG.
  - else strt_mv -> load frwrd_spd = MIN_FRWRD next clock; go to ACCEL, or to DEC_FAST if frwrd_opn = 0 in that cycle.
  - If strt_hdng and strt_mv arrive in the same cycle, strt_hdng wins and strt_mv is dropped.
- HDNG:
  - frwrd_spd held at 0.
  - When at_hdng = 1: mv_cmplt = 1 that cycle, then IDLE.
- ACCEL, evaluated in priority order:
  - 1. frwrd_opn = 0 -> DEC_FAST.
  - 2. (stp_lft & lft_rise) | (stp_rght & rght_rise) -> DEC_NORM.
  - 3. otherwise, on hdng_rdy: frwrd_spd += FRWRD_INC, clamped to MAX_FRWRD. frwrd_spd never exceeds MAX_FRWRD.
- DEC_NORM:
  - On hdng_rdy: frwrd_spd -= 2*FRWRD_INC.
  - frwrd_opn = 0 in this state -> DEC_FAST.
- DEC_FAST:
  - On hdng_rdy: frwrd_spd -= 4*FRWRD_INC.
- Stop rule (both decel states): if the decremented value would be < MIN_FRWRD, or would underflow (compare at 12 bits), then:
  - frwrd_spd <= 0;
  - mv_cmplt = 1 in that cycle;
  - next state = IDLE.
- mv_cmplt is combinational from state and inputs, exactly one cycle wide, and never asserted in IDLE.
- strt_hdng and strt_mv are ignored outside IDLE.
- en_fusion and moving are derived combinationally from the registered frwrd_spd and state.
- Asserting rst_n low mid-move returns everything to the reset values immediately (asynchronous). No mv_cmplt is issued.

Test Plan:
- FAST_SIM=1, frwrd_opn=1, strt_mv pulse:
  - frwrd_spd = 0x0D0 one clock later.
  - Each hdng_rdy adds 0x18; after 19 strobes frwrd_spd = 0x298; the 20th clamps to 0x2A0 and it stays there.
  - en_fusion rises once frwrd_spd > 0x150.
- From 0x2A0 with stp_lft=1, raise lft_opn 0->1:
  - DEC_NORM; each hdng_rdy subtracts 0x30; after 9 strobes frwrd_spd = 0x0F0.
  - 10th strobe -> frwrd_spd = 0, a single mv_cmplt pulse, moving = 0.
- From 0x2A0, drop frwrd_opn to 0:
  - frwrd_spd steps 0x240, 0x1E0, 0x180, 0x120.
  - 5th strobe -> 0, mv_cmplt pulse, IDLE.
- lft_opn already 1 at strt_mv with stp_lft=1:
  - No decel; the ramp continues.
  - A later 0->1 edge on rght_opn with stp_rght=0 is also ignored.
- strt_hdng and strt_mv in the same cycle:
  - HDNG entered, frwrd_spd stays 0.
  - at_hdng=1 -> one mv_cmplt, IDLE.
  - A strt_mv issued while in HDNG has no effect.
- Reset asserted at frwrd_spd = 0x1E0 in ACCEL:
  - frwrd_spd, moving, en_fusion, mv_cmplt = 0 asynchronously.
  - After release the block is in IDLE and accepts a new strt_mv normally.
